hazard_bubble_ctrl: RTL and testbench

//  Hazard and bubble controller: the producer side of the ID/EXE bubble and IF/ID stall/flush controls.
//  - Keeps a shadow scoreboard of the EXE/MEM destinations, forwarding-select outputs steer the ID-stage operand muxes.
//  - Detects load-use hazards and stalls for LOAD_USE_STALL cycles.
//  - Flushes wrong-path instructions when a branch resolves taken in EXE (predict-not-taken).

---
 rtl/hazard_bubble_ctrl.sv | 98 +++++++++
 tb/tb_hazard_bubble_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_bubble_ctrl.sv
// hazard_bubble_ctrl: EXE/MEM shadow scoreboard, operand forwarding selects, load-use stall and taken-branch flush control.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined; otherwise the perf ports read 0.
module hazard_bubble_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_en,
    input  logic [4:0]       ID_rs_addr,
    input  logic [4:0]       ID_rt_addr,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_RegWrite,
    input  logic             ID_DatatoReg,
    input  logic [4:0]       ID_wr_addr,
    input  logic             EXE_branch_taken,
    output logic             pc_en,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EXE_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] wr_addr;
        logic       is_load;
    } slot_t;

    state_t     state;
    logic [1:0] stall_cnt;
    slot_t      sb_exe, sb_mem;
    logic       rs_hit_exe, rs_hit_mem, rt_hit_exe, rt_hit_mem;
    logic       hazard, in_stall, branch_ev, haz_ev;

    assign rs_hit_exe = ID_uses_rs && sb_exe.valid && sb_exe.wr_addr == ID_rs_addr;
    assign rs_hit_mem = ID_uses_rs && sb_mem.valid && sb_mem.wr_addr == ID_rs_addr;
    assign rt_hit_exe = ID_uses_rt && sb_exe.valid && sb_exe.wr_addr == ID_rt_addr;
    assign rt_hit_mem = ID_uses_rt && sb_mem.valid && sb_mem.wr_addr == ID_rt_addr;
    assign hazard     = (rs_hit_exe || rt_hit_exe) && sb_exe.is_load;

    // A branch only redirects from RUN; in FLUSH the slot behind it is a bubble, so hazard logic alone applies.
    assign in_stall  = state == STALL;
    assign branch_ev = state == RUN && EXE_branch_taken;
    assign haz_ev    = !in_stall && !branch_ev && hazard;

    assign pc_en         = !reset && !in_stall && !haz_ev;
    assign IF_ID_stall   = !reset && (in_stall || haz_ev);
    assign IF_ID_flush   = reset || branch_ev;
    assign ID_EXE_bubble = reset || branch_ev || haz_ev || in_stall;
    assign fwd_a_sel = reset ? 2'b00 : (rs_hit_exe && !sb_exe.is_load) ? 2'b01 : rs_hit_mem ? 2'b10 : 2'b00;
    assign fwd_b_sel = reset ? 2'b00 : (rt_hit_exe && !sb_exe.is_load) ? 2'b01 : rt_hit_mem ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
            sb_exe    <= '0;
            sb_mem    <= '0;
        end else if (cpu_en) begin
            sb_mem <= sb_exe;
            sb_exe <= ID_EXE_bubble ? '0 : slot_t'({ID_RegWrite && ID_wr_addr != 5'd0, ID_wr_addr, ID_DatatoReg});
            if (branch_ev) begin
                state <= FLUSH;
            end else if (haz_ev) begin
                stall_cnt <= 2'(LOAD_USE_STALL - 1);
                state     <= LOAD_USE_STALL > 1 ? STALL : RUN;
            end else if (in_stall) begin
                stall_cnt <= stall_cnt - 2'd1;
                state     <= stall_cnt <= 2'd1 ? RUN : STALL;
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (cpu_en && !pc_en && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (cpu_en && branch_ev && !(&flush_q)) flush_q <= flush_q + 1'b1;
        end
    end
    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// tb_hazard_bubble_ctrl: directed checks of forwarding, load-use stalls (1 and 3 cycles), branch flush and reset.
module tb_hazard_bubble_ctrl;
    logic clk = 1'b0;
    logic reset, cpu_en, ID_uses_rs, ID_uses_rt, ID_RegWrite, ID_DatatoReg, EXE_branch_taken;
    logic [4:0] ID_rs_addr, ID_rt_addr, ID_wr_addr;
    logic pc_en, IF_ID_stall, IF_ID_flush, ID_EXE_bubble;
    logic pc_en3, IF_ID_stall3, IF_ID_flush3, ID_EXE_bubble3;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel3, fwd_b_sel3;
    logic [15:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt3, perf_flush_cnt3;
    logic [7:0] ctl, ctl3;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_bubble_ctrl #(.LOAD_USE_STALL(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_RegWrite(ID_RegWrite), .ID_DatatoReg(ID_DatatoReg), .ID_wr_addr(ID_wr_addr),
        .EXE_branch_taken(EXE_branch_taken),
        .pc_en(pc_en), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EXE_bubble(ID_EXE_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    hazard_bubble_ctrl #(.LOAD_USE_STALL(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_RegWrite(ID_RegWrite), .ID_DatatoReg(ID_DatatoReg), .ID_wr_addr(ID_wr_addr),
        .EXE_branch_taken(EXE_branch_taken),
        .pc_en(pc_en3), .IF_ID_stall(IF_ID_stall3), .IF_ID_flush(IF_ID_flush3),
        .ID_EXE_bubble(ID_EXE_bubble3), .fwd_a_sel(fwd_a_sel3), .fwd_b_sel(fwd_b_sel3),
        .perf_stall_cnt(perf_stall_cnt3), .perf_flush_cnt(perf_flush_cnt3)
    );

    // {pc_en, stall, flush, bubble, fwd_a[1:0], fwd_b[1:0]}
    assign ctl  = {pc_en, IF_ID_stall, IF_ID_flush, ID_EXE_bubble, fwd_a_sel, fwd_b_sel};
    assign ctl3 = {pc_en3, IF_ID_stall3, IF_ID_flush3, ID_EXE_bubble3, fwd_a_sel3, fwd_b_sel3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic rw, input logic ld, input logic [4:0] wr);
        ID_rs_addr = rs; ID_rt_addr = rt; ID_uses_rs = urs; ID_uses_rt = urt;
        ID_RegWrite = rw; ID_DatatoReg = ld; ID_wr_addr = wr;
        #1;
    endtask

    task automatic nop();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic flush_pipe();
        nop();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_en = 1'b1; EXE_branch_taken = 1'b0;
        nop();
        tick();
        checks++;
        if (ctl !== 8'b0011_0000) begin fails++; $display("FAIL reset_forced: ctl=%b expected 00110000", ctl); end
        checks++;
        if (ctl3 !== 8'b0011_0000) begin fails++; $display("FAIL reset_forced3: ctl=%b expected 00110000", ctl3); end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== 8'b1000_0000) begin fails++; $display("FAIL reset_idle: ctl=%b expected 10000000", ctl); end
        checks++;
        if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_perf: stall=%0d flush=%0d expected 0 0", perf_stall_cnt, perf_flush_cnt);
        end
    endtask

    task automatic test_forwarding();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        tick();
        id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        checks++;
        if (ctl !== 8'b1000_0100) begin fails++; $display("FAIL fwd_exe: ctl=%b expected 10000100", ctl); end
        tick();
        id(5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ctl !== 8'b1000_0110) begin fails++; $display("FAIL fwd_exe_mem: ctl=%b expected 10000110", ctl); end
        tick();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        tick();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        checks++;
        if (ctl !== 8'b1000_0000) begin fails++; $display("FAIL fwd_none: ctl=%b expected 10000000", ctl); end
        tick();
        id(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ctl !== 8'b1000_0101) begin fails++; $display("FAIL fwd_priority: ctl=%b expected 10000101", ctl); end
        id(5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ctl !== 8'b1000_0001) begin fails++; $display("FAIL fwd_uses_rs: ctl=%b expected 10000001", ctl); end
        flush_pipe();
    endtask

    task automatic test_load_use();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        checks++;
        if (ctl !== 8'b0101_0000) begin fails++; $display("FAIL lu_stall: ctl=%b expected 01010000", ctl); end
        tick();
        checks++;
        if (ctl !== 8'b1000_1010) begin fails++; $display("FAIL lu_release: ctl=%b expected 10001010", ctl); end
        flush_pipe();
    endtask

    task automatic test_stall3_freeze();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        checks++;
        if (ctl3 !== 8'b0101_0000) begin fails++; $display("FAIL lu3_c1: ctl=%b expected 01010000", ctl3); end
        tick();
        checks++;
        if (ctl3 !== 8'b0101_1010) begin fails++; $display("FAIL lu3_c2: ctl=%b expected 01011010", ctl3); end
        cpu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ctl3 !== 8'b0101_1010) begin fails++; $display("FAIL lu3_frozen: ctl=%b expected 01011010", ctl3); end
        end
        cpu_en = 1'b1;
        tick();
        checks++;
        if (ctl3 !== 8'b0101_0000) begin fails++; $display("FAIL lu3_c3: ctl=%b expected 01010000", ctl3); end
        tick();
        checks++;
        if (ctl3 !== 8'b1000_0000) begin fails++; $display("FAIL lu3_run: ctl=%b expected 10000000", ctl3); end
        flush_pipe();
    endtask

    task automatic test_branch();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        EXE_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== 8'b1011_0000) begin fails++; $display("FAIL br_beats_hazard: ctl=%b expected 10110000", ctl); end
        tick();
        EXE_branch_taken = 1'b0;
        id(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ctl !== 8'b1000_1000) begin fails++; $display("FAIL br_flush_state: ctl=%b expected 10001000", ctl); end
        flush_pipe();
    endtask

    task automatic test_zero_reg();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        tick();
        id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        checks++;
        if (ctl !== 8'b1000_0000) begin fails++; $display("FAIL zero_reg: ctl=%b expected 10000000", ctl); end
        flush_pipe();
    endtask

    task automatic test_reset_mid_stall();
        id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        checks++;
        if (ctl3 !== 8'b0101_1010) begin fails++; $display("FAIL rst_pre_stall: ctl=%b expected 01011010", ctl3); end
        reset = 1'b1;
        #1;
        checks++;
        if (ctl3 !== 8'b0011_0000) begin fails++; $display("FAIL rst_forced_stall: ctl=%b expected 00110000", ctl3); end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl3 !== 8'b1000_0000) begin fails++; $display("FAIL rst_run_clear: ctl=%b expected 10000000", ctl3); end
        checks++;
        if (perf_stall_cnt3 !== 16'd0 || perf_flush_cnt3 !== 16'd0) begin
            fails++; $display("FAIL rst_perf: stall=%0d flush=%0d expected 0 0", perf_stall_cnt3, perf_flush_cnt3);
        end
        tick();
        checks++;
        if (ctl3 !== 8'b1000_0000) begin fails++; $display("FAIL rst_slots_clear: ctl=%b expected 10000000", ctl3); end
        flush_pipe();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_stall3_freeze();
        test_branch();
        test_zero_reg();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
